// File: rtl/ball_position_if.sv
// Plot request channel between the ball position engine and the VGA plotter front-end.
// The ball engine is the master: it drives the request and its payload, and the plotter returns ack.
interface ball_position_if;
    logic [9:0] plot_x;
    logic [9:0] plot_y;
    logic [2:0] plot_colour;
    logic       plot_req;
    logic       plot_ack;

    modport master (
        output plot_x,
        output plot_y,
        output plot_colour,
        output plot_req,
        input  plot_ack
    );

    modport slave (
        input  plot_x,
        input  plot_y,
        input  plot_colour,
        input  plot_req,
        output plot_ack
    );
endinterface

// File: rtl/ball_position.sv
// Ball sprite position engine.
// On each frame tick the ball steps along x and y and stops at the play-field bounds.
// Each move is wrapped in plot requests to the plotter over a req/ack handshake.
// Optional feature: define BALL_POS_ERASE_EN to issue a colour-0 erase request at the old
// position before each move. Without it, a tick goes straight to MOVE and only the draw
// request is issued.
module ball_position #(
    parameter int unsigned MAX_X       = 160,
    parameter int unsigned MAX_Y       = 120,
    parameter int unsigned SIZE        = 4,
    parameter int unsigned STEP        = 1,
    parameter int unsigned START_X     = 78,
    parameter int unsigned START_Y     = 100,
    parameter logic [2:0]  BALL_COLOUR = 3'b111
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic           x_du,
    input  logic           y_du,
    output logic [9:0]     x,
    output logic [9:0]     y,
    output logic           busy,
    ball_position_if.master plot
);

    localparam int unsigned CW = 10;
    localparam int unsigned AW = 11;
    localparam logic [AW-1:0] X_LIM  = AW'(MAX_X - SIZE);
    localparam logic [AW-1:0] Y_LIM  = AW'(MAX_Y - SIZE);
    localparam logic [AW-1:0] STEP_W = AW'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        MOVE  = 2'd2,
        DRAW  = 2'd3
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  x_q;
    logic [CW-1:0]  y_q;
    logic [CW-1:0]  x_d;
    logic [CW-1:0]  y_d;
    logic [AW-1:0]  x_sum;
    logic [AW-1:0]  y_sum;
    logic [CW-1:0]  plot_x_q;
    logic [CW-1:0]  plot_y_q;
    logic [2:0]     plot_colour_q;
    logic           plot_req_q;
    logic           busy_q;

    // Next position with clamping; sums are one bit wider so they cannot wrap.
    always_comb begin
        x_sum = {1'b0, x_q} + STEP_W;
        y_sum = {1'b0, y_q} + STEP_W;
        x_d   = x_q;
        y_d   = y_q;
        if (x_du) begin
            x_d = (x_sum > X_LIM) ? CW'(X_LIM) : CW'(x_sum);
        end else begin
            x_d = ({1'b0, x_q} < STEP_W) ? '0 : CW'({1'b0, x_q} - STEP_W);
        end
        if (y_du) begin
            y_d = (y_sum > Y_LIM) ? CW'(Y_LIM) : CW'(y_sum);
        end else begin
            y_d = ({1'b0, y_q} < STEP_W) ? '0 : CW'({1'b0, y_q} - STEP_W);
        end
    end

    // Move sequencer; position, request payload and busy are all registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            x_q           <= CW'(START_X);
            y_q           <= CW'(START_Y);
            plot_x_q      <= '0;
            plot_y_q      <= '0;
            plot_colour_q <= '0;
            plot_req_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        busy_q <= 1'b1;
`ifdef BALL_POS_ERASE_EN
                        state_q       <= ERASE;
                        plot_x_q      <= x_q;
                        plot_y_q      <= y_q;
                        plot_colour_q <= 3'd0;
                        plot_req_q    <= 1'b1;
`else
                        state_q       <= MOVE;
`endif
                    end
                end
`ifdef BALL_POS_ERASE_EN
                ERASE: begin
                    if (plot.plot_ack) begin
                        state_q    <= MOVE;
                        plot_req_q <= 1'b0;
                    end
                end
`endif
                MOVE: begin
                    // Direction bits are sampled here, not at the tick.
                    x_q           <= x_d;
                    y_q           <= y_d;
                    plot_x_q      <= x_d;
                    plot_y_q      <= y_d;
                    plot_colour_q <= BALL_COLOUR;
                    plot_req_q    <= 1'b1;
                    state_q       <= DRAW;
                end
                DRAW: begin
                    if (plot.plot_ack) begin
                        state_q    <= IDLE;
                        plot_req_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    plot_req_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign x                = x_q;
    assign y                = y_q;
    assign busy             = busy_q;
    assign plot.plot_x      = plot_x_q;
    assign plot.plot_y      = plot_y_q;
    assign plot.plot_colour = plot_colour_q;
    assign plot.plot_req    = plot_req_q;

endmodule

// File: tb/tb_ball_position.sv
// Directed bench for ball_position: reset, single move, busy tick drop, async reset mid-draw,
// and bound clamping with STEP=3. Expectations follow BALL_POS_ERASE_EN if it is defined.
module tb_ball_position;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       tick_c;
    logic       x_du;
    logic       y_du;
    logic [9:0] x, y, xa, ya, xb, yb;
    logic       busy, busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ball_position_if pif ();
    ball_position_if pif_a ();
    ball_position_if pif_b ();

    // Clamp instances are served by a plotter that acks every request straight away.
    assign pif_a.plot_ack = pif_a.plot_req;
    assign pif_b.plot_ack = pif_b.plot_req;

    ball_position dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .x_du  (x_du),
        .y_du  (y_du),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .plot  (pif)
    );

    ball_position #(.STEP(3), .START_X(155), .START_Y(116)) dut_a (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_c),
        .x_du  (1'b1),
        .y_du  (1'b1),
        .x     (xa),
        .y     (ya),
        .busy  (busy_a),
        .plot  (pif_a)
    );

    ball_position #(.STEP(3), .START_X(1), .START_Y(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_c),
        .x_du  (1'b0),
        .y_du  (1'b0),
        .x     (xb),
        .y     (yb),
        .busy  (busy_b),
        .plot  (pif_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Bounded wait for a request from the main instance.
    task automatic wait_req(input string tag);
        int n = 0;
        while (pif.plot_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_req"}, 32'(pif.plot_req), 1);
    endtask

    // Check one request, hold it two cycles, ack it, then check it was released.
    task automatic serve_req(input string tag, input int ex, input int ey, input int ec,
                             input bit pulse, input bit is_draw);
        wait_req(tag);
        check_eq({tag, "_x"}, 32'(pif.plot_x), ex);
        check_eq({tag, "_y"}, 32'(pif.plot_y), ey);
        check_eq({tag, "_col"}, 32'(pif.plot_colour), ec);
        check_eq({tag, "_busy"}, 32'(busy), 1);
        if (pulse) tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        check_eq({tag, "_hold_req"}, 32'(pif.plot_req), 1);
        check_eq({tag, "_hold_x"}, 32'(pif.plot_x), ex);
        pif.plot_ack = 1'b1;
        if (pulse) tick = 1'b1;
        @(negedge clk);
        pif.plot_ack = 1'b0;
        tick = 1'b0;
        check_eq({tag, "_rel_req"}, 32'(pif.plot_req), 0);
        check_eq({tag, "_rel_busy"}, 32'(busy), is_draw ? 0 : 1);
    endtask

    initial begin
        reset        = 1'b1;
        tick         = 1'b0;
        tick_c       = 1'b0;
        x_du         = 1'b1;
        y_du         = 1'b0;
        pif.plot_ack = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check_eq("rst_x", 32'(x), 78);
        check_eq("rst_y", 32'(y), 100);
        check_eq("rst_req", 32'(pif.plot_req), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_px", 32'(pif.plot_x), 0);
        check_eq("rst_col", 32'(pif.plot_colour), 0);
        check_eq("rst_xa", 32'(xa), 155);
        reset = 1'b0;
        @(negedge clk);

        // Single move: +x, -y
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
`ifdef BALL_POS_ERASE_EN
        serve_req("erase", 78, 100, 0, 1'b0, 1'b0);
        check_eq("move_x_old", 32'(x), 78);
`else
        check_eq("move_busy", 32'(busy), 1);
        check_eq("move_noreq", 32'(pif.plot_req), 0);
        check_eq("move_x_old", 32'(x), 78);
        @(negedge clk);
        check_eq("move_x_new", 32'(x), 79);
`endif
        serve_req("draw", 79, 99, 7, 1'b0, 1'b1);
        check_eq("move_x", 32'(x), 79);
        check_eq("move_y", 32'(y), 99);

        // Ticks while busy are dropped, including one coincident with the draw ack
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tick = 1'b0;
`ifdef BALL_POS_ERASE_EN
        serve_req("drop_erase", 78, 100, 0, 1'b1, 1'b0);
`endif
        serve_req("drop_draw", 79, 99, 7, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("drop_req", 32'(pif.plot_req), 0);
        check_eq("drop_busy", 32'(busy), 0);
        check_eq("drop_x", 32'(x), 79);
        check_eq("drop_y", 32'(y), 99);

        // Async reset while the draw request is pending
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
`ifdef BALL_POS_ERASE_EN
        serve_req("rd_erase", 79, 99, 0, 1'b0, 1'b0);
`endif
        wait_req("rd_draw");
        check_eq("rd_draw_x", 32'(pif.plot_x), 80);
        #2 reset = 1'b1;
        #1;
        check_eq("rd_req", 32'(pif.plot_req), 0);
        check_eq("rd_x", 32'(x), 78);
        check_eq("rd_y", 32'(y), 100);
        check_eq("rd_busy", 32'(busy), 0);
        check_eq("rd_px", 32'(pif.plot_x), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rd_idle_busy", 32'(busy), 0);

        // Clamping with STEP=3, two moves each
        for (int m = 0; m < 2; m++) begin
            int n = 0;
            tick_c = 1'b1;
            @(negedge clk);
            tick_c = 1'b0;
            while ((busy_a || busy_b) && n < 20) begin
                @(negedge clk);
                n++;
            end
            check_eq("clamp_busy", 32'(busy_a | busy_b), 0);
            check_eq("clamp_xa", 32'(xa), 156);
            check_eq("clamp_ya", 32'(ya), 116);
            check_eq("clamp_xb", 32'(xb), 0);
            check_eq("clamp_yb", 32'(yb), 0);
        end
        check_eq("clamp_pxa", 32'(pif_a.plot_x), 156);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ball_position.md
# ball_position

Sequential position engine for the ball sprite. It consumes the per-axis direction bits produced by the ball bounce logic (`x_du`/`y_du`) and advances the ball's x/y registers once per frame tick, clamping at the play-field bounds. Each move is bracketed by an erase/draw request sequence towards the VGA plotter, using a req/ack handshake. The block sits between the bounce logic, which reads `x`/`y`, and the shared plotter front-end.

## Interface
Parameters:
- `MAX_X`, 160: play-field width in pixels.
- `MAX_Y`, 120: play-field height in pixels.
- `SIZE`, 4: ball edge length. Upper position bound is `MAX_-SIZE`.
- `STEP`, 1: pixels moved per tick per axis (1..15).
- `START_X`, 78: x position after reset.
- `START_Y`, 100: y position after reset.
- `BALL_COLOUR`, 3'b111: colour used for the draw request.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  single-cycle frame-rate move strobe.
- `x_du`  in  1  1 = move +x, 0 = move −x.
- `y_du`  in  1  1 = move +y, 0 = move −y.
- `x`  out  10  current ball x (registered).
- `y`  out  10  current ball y (registered).
- `plot_x`  out  10  plot request x.
- `plot_y`  out  10  plot request y.
- `plot_colour`  out  3  plot request colour.
- `plot_req`  out  1  plot request valid.
- `plot_ack`  in  1  plotter has accepted/finished the request.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ERASE, MOVE, DRAW.
- **IDLE:** `tick`=1 transitions to ERASE. Ticks in any other state are dropped, not queued.
- **ERASE:** drives `plot_req`=1, `plot_x`/`plot_y` = current `x`/`y`, `plot_colour`=0. Holds until `plot_ack` is sampled high, then goes to MOVE.
- **MOVE:** lasts one cycle. `x`/`y` load the next position, then the FSM goes to DRAW.
- **DRAW:** drives `plot_req`=1, `plot_x`/`plot_y` = updated `x`/`y`, `plot_colour`=`BALL_COLOUR`. When `plot_ack` is sampled high, the FSM returns to IDLE.
- Next-x rule, computed in 11 bits to avoid wrap:
  - `x_du`=1: `min(x+STEP, MAX_X-SIZE)`.
  - `x_du`=0: `(x<STEP) ? 0 : x-STEP`.
  - y uses the same rule with `MAX_Y` and `y_du`.
- `x_du`/`y_du` are sampled in MOVE, not at the tick.
- `plot_ack` is ignored in IDLE and MOVE.
- `plot_x`, `plot_y`, `plot_colour` and `plot_req` are registered outputs.

## Timing
- Reset (async, any state, including mid-handshake):
  - state = IDLE.
  - `x`=`START_X`, `y`=`START_Y`.
  - `plot_req`=0, `plot_x`=0, `plot_y`=0, `plot_colour`=0, `busy`=0.
- Tick sampled at edge n: `plot_req`=1 and `busy`=1 after edge n.
- Ack sampled at edge m in ERASE: MOVE after m, `x`/`y` updated after m+1, DRAW request valid after m+1.
- Ack sampled at edge k in DRAW: `plot_req`=0 and `busy`=0 after k. The earliest next tick is accepted at k+1.
- Minimum tick-to-idle is 4 cycles, with ack high on the first request cycle.
- `plot_req` never drops before ack. The request payload is stable while `plot_req`=1.
- If `tick` and ack arrive on the same cycle in DRAW, the tick is dropped.

## Configuration
- `BALL_POS_ERASE_EN` defined: full IDLE→ERASE→MOVE→DRAW sequence as above.
- `BALL_POS_ERASE_EN` undefined:
  - ERASE state is removed and a tick goes IDLE→MOVE directly.
  - No colour-0 request is ever issued; background is restored elsewhere.
  - Minimum tick-to-idle is 3 cycles.

## Test plan
- **Reset:** assert `reset` → `x`=78, `y`=100, `plot_req`=0, `busy`=0.
- **Single move:** defaults, `x_du`=1, `y_du`=0, tick, ack 2 cycles after each req →
  - erase request (78,100), colour 0;
  - then `x`=79, `y`=99;
  - draw request (79,99), colour 7;
  - `busy` falls.
- **Clamp:** with `STEP`=3 →
  - x=155, `x_du`=1 → x=156;
  - x=1, `x_du`=0 → x=0;
  - y=116, `y_du`=1 → y=116.
- **Busy tick drop:** tick pulses during ERASE and DRAW → exactly one move (x 78→79); no second request.
- **Reset mid-DRAW:** assert `reset` while `plot_req`=1 → `plot_req`=0 immediately (async); x=78, y=100; state IDLE.
- **Macro off:** `BALL_POS_ERASE_EN` undefined, tick →
  - no colour-0 request;
  - x updates 2 cycles after the tick;
  - a single draw request at the new position.
